// File: rtl/approx_mult_err_monitor.sv
// Error-statistics monitor for approximate N x N multipliers: sample count, mismatch count,
// error-distance sum and maximum. ERR_MON_WORST_CAPTURE_EN adds worst_a/worst_b/worst_y capture.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | after reset, samples ignored, waiting for start
// RUN    | in_ready=1, samples accepted until one carries in_last
// DRAIN  | two cycles letting the last sample reach the accumulators
// DONE   | done pulses on entry, statistics final and held
module approx_mult_err_monitor #(
   parameter int N     = 8,
   parameter int CNT_W = 17,
   parameter int SUM_W = 33
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             in_valid,
   input  logic             in_last,
   input  logic [N-1:0]     a,
   input  logic [N-1:0]     b,
   input  logic [2*N-1:0]   Y,
   output logic             in_ready,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] sample_cnt,
   output logic [CNT_W-1:0] err_cnt,
   output logic [SUM_W-1:0] ed_sum,
`ifdef ERR_MON_WORST_CAPTURE_EN
   output logic [N-1:0]     worst_a,
   output logic [N-1:0]     worst_b,
   output logic [2*N-1:0]   worst_y,
`endif
   output logic [2*N-1:0]   ed_max
);

   localparam int PW = 2 * N;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t state_q, state_d;
   logic   drain_q, drain_d;
   logic   done_q, done_d;
   logic   accept;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         drain_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         drain_q <= drain_d;
         done_q  <= done_d;
      end
   end

   // ---------------- FSM: next state ----------------
   // Drain is a down-counter loaded on the last sample; terminal count 0 enters DONE,
   // which lines up with the last sample landing in the accumulators.
   always_comb begin
      state_d = state_q;
      drain_d = drain_q;
      done_d  = 1'b0;
      if (start) begin
         state_d = S_RUN;
         drain_d = 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: ;
            S_RUN: begin
               if (in_valid && in_last) begin
                  state_d = S_DRAIN;
                  drain_d = 1'b1;
               end
            end
            S_DRAIN: begin
               if (drain_q == 1'b0) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
               end else begin
                  drain_d = drain_q - 1'b1;
               end
            end
            S_DONE: ;
            default: state_d = S_IDLE;
         endcase
      end
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      in_ready = (state_q == S_RUN);
      busy     = (state_q == S_RUN) || (state_q == S_DRAIN);
      done     = done_q;
   end

   assign accept = (state_q == S_RUN) && in_valid && !start;

   // ---------------- stage 1: input capture ----------------
   logic          s1_vld_q;
   logic [N-1:0]  s1_a_q, s1_b_q;
   logic [PW-1:0] s1_y_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_vld_q <= 1'b0;
         s1_a_q   <= '0;
         s1_b_q   <= '0;
         s1_y_q   <= '0;
      end else begin
         s1_vld_q <= accept;
         if (accept) begin
            s1_a_q <= a;
            s1_b_q <= b;
            s1_y_q <= Y;
         end
      end
   end

   // ---------------- stage 2: exact product and error distance ----------------
   logic [PW-1:0] exact_c, ed_c;
   logic          s2_vld_q, s2_mis_q;
   logic [PW-1:0] s2_ed_q;

   assign exact_c = {{N{1'b0}}, s1_a_q} * {{N{1'b0}}, s1_b_q};
   assign ed_c    = (exact_c >= s1_y_q) ? (exact_c - s1_y_q) : (s1_y_q - exact_c);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_vld_q <= 1'b0;
         s2_mis_q <= 1'b0;
         s2_ed_q  <= '0;
      end else begin
         s2_vld_q <= s1_vld_q && !start;
         if (s1_vld_q) begin
            s2_ed_q  <= ed_c;
            s2_mis_q <= (ed_c != '0);
         end
      end
   end

`ifdef ERR_MON_WORST_CAPTURE_EN
   logic [N-1:0]  s2_a_q, s2_b_q;
   logic [PW-1:0] s2_y_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_a_q <= '0;
         s2_b_q <= '0;
         s2_y_q <= '0;
      end else if (s1_vld_q) begin
         s2_a_q <= s1_a_q;
         s2_b_q <= s1_b_q;
         s2_y_q <= s1_y_q;
      end
   end
`endif

   // ---------------- stage 3: saturating accumulators ----------------
   logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;
   logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
   logic [SUM_W-1:0] ed_sum_q, ed_sum_d;
   logic [PW-1:0]    ed_max_q, ed_max_d;
   logic [CNT_W:0]   cnt_inc, err_inc;
   logic [SUM_W:0]   sum_inc;

   assign cnt_inc = {1'b0, sample_cnt_q} + {{CNT_W{1'b0}}, 1'b1};
   assign err_inc = {1'b0, err_cnt_q} + {{CNT_W{1'b0}}, s2_mis_q};
   assign sum_inc = {1'b0, ed_sum_q} + {{(SUM_W + 1 - PW){1'b0}}, s2_ed_q};

`ifdef ERR_MON_WORST_CAPTURE_EN
   logic [N-1:0]  worst_a_q, worst_a_d, worst_b_q, worst_b_d;
   logic [PW-1:0] worst_y_q, worst_y_d;
`endif

   always_comb begin
      sample_cnt_d = sample_cnt_q;
      err_cnt_d    = err_cnt_q;
      ed_sum_d     = ed_sum_q;
      ed_max_d     = ed_max_q;
`ifdef ERR_MON_WORST_CAPTURE_EN
      worst_a_d    = worst_a_q;
      worst_b_d    = worst_b_q;
      worst_y_d    = worst_y_q;
`endif
      if (start) begin
         sample_cnt_d = '0;
         err_cnt_d    = '0;
         ed_sum_d     = '0;
         ed_max_d     = '0;
`ifdef ERR_MON_WORST_CAPTURE_EN
         worst_a_d    = '0;
         worst_b_d    = '0;
         worst_y_d    = '0;
`endif
      end else if (s2_vld_q) begin
         sample_cnt_d = cnt_inc[CNT_W] ? {CNT_W{1'b1}} : cnt_inc[CNT_W-1:0];
         err_cnt_d    = err_inc[CNT_W] ? {CNT_W{1'b1}} : err_inc[CNT_W-1:0];
         ed_sum_d     = sum_inc[SUM_W] ? {SUM_W{1'b1}} : sum_inc[SUM_W-1:0];
         // Strict compare so a tie keeps the earliest worst sample.
         if (s2_ed_q > ed_max_q) begin
            ed_max_d  = s2_ed_q;
`ifdef ERR_MON_WORST_CAPTURE_EN
            worst_a_d = s2_a_q;
            worst_b_d = s2_b_q;
            worst_y_d = s2_y_q;
`endif
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sample_cnt_q <= '0;
         err_cnt_q    <= '0;
         ed_sum_q     <= '0;
         ed_max_q     <= '0;
      end else begin
         sample_cnt_q <= sample_cnt_d;
         err_cnt_q    <= err_cnt_d;
         ed_sum_q     <= ed_sum_d;
         ed_max_q     <= ed_max_d;
      end
   end

`ifdef ERR_MON_WORST_CAPTURE_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         worst_a_q <= '0;
         worst_b_q <= '0;
         worst_y_q <= '0;
      end else begin
         worst_a_q <= worst_a_d;
         worst_b_q <= worst_b_d;
         worst_y_q <= worst_y_d;
      end
   end

   assign worst_a = worst_a_q;
   assign worst_b = worst_b_q;
   assign worst_y = worst_y_q;
`endif

   assign sample_cnt = sample_cnt_q;
   assign err_cnt    = err_cnt_q;
   assign ed_sum     = ed_sum_q;
   assign ed_max     = ed_max_q;

endmodule
